// File: rtl/regfile_bist.sv
// regfile_bist: self-test initiator that writes a pattern to all 32 RegisterFile entries
// and reads them back through both ports, reporting error count and first failing register.
module regfile_bist #(
    parameter logic [31:0] SEED   = 32'hA5C30F00,
    parameter int          PASSES = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [31:0] BusA,
    input  logic [31:0] BusB,
    output logic [4:0]  RA,
    output logic [4:0]  RB,
    output logic [4:0]  RW,
    output logic [31:0] BusW,
    output logic        RegWr,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [5:0]  ErrCount,
    output logic [4:0]  FirstErrReg
);
    typedef enum logic [2:0] {IDLE, WRITE, RD_SET, RD_CHK, DONE} state_t;
    localparam logic [1:0] LAST_PASS = 2'(PASSES - 1);
    state_t      state;
    logic [4:0]  idx, idxB;
    logic [1:0]  passIdx;
    logic        missA, missB;
    logic [6:0]  errSum;
    function automatic logic [31:0] expVal(input logic [1:0] p, input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : (SEED ^ {27'b0, i}) ^ {32{p[0]}};
    endfunction
    // $0 gets all-ones so a register file that fails to discard it is caught
    function automatic logic [31:0] wrVal(input logic [1:0] p, input logic [4:0] i);
        return (i == 5'd0) ? 32'hFFFFFFFF : expVal(p, i);
    endfunction
    always_comb begin
        idxB   = idx + 5'd1;
        missA  = BusA != expVal(passIdx, idx);
        missB  = BusB != expVal(passIdx, idxB);
        errSum = {1'b0, ErrCount} + {6'b0, missA} + {6'b0, missB};
    end
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state       <= IDLE;
            idx         <= 5'd0;
            passIdx     <= 2'd0;
            RA          <= 5'd0;
            RB          <= 5'd0;
            RW          <= 5'd0;
            BusW        <= 32'd0;
            RegWr       <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Pass        <= 1'b0;
            ErrCount    <= 6'd0;
            FirstErrReg <= 5'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        ErrCount    <= 6'd0;
                        FirstErrReg <= 5'd0;
                        Done        <= 1'b0;
                        Pass        <= 1'b0;
                        Busy        <= 1'b1;
                        passIdx     <= 2'd0;
                        idx         <= 5'd0;
                        RegWr       <= 1'b1;
                        RW          <= 5'd0;
                        BusW        <= wrVal(2'd0, 5'd0);
                        state       <= WRITE;
                    end else if (state == DONE) begin
                        Busy <= 1'b0;
                        Done <= 1'b1;
                        Pass <= ErrCount == 6'd0;
                    end
                end
                WRITE: begin
                    if (idx == 5'd31) begin
                        RegWr <= 1'b0;
                        RW    <= 5'd0;
                        BusW  <= 32'd0;
                        idx   <= 5'd0;
                        state <= RD_SET;
                    end else begin
                        idx  <= idxB;
                        RW   <= idxB;
                        BusW <= wrVal(passIdx, idxB);
                    end
                end
                RD_SET: begin
                    RA    <= idx;
                    RB    <= idxB;
                    state <= RD_CHK;
                end
                RD_CHK: begin
                    ErrCount <= (errSum > 7'd63) ? 6'd63 : errSum[5:0];
                    // A zero count means no mismatch yet, so this is the first one
                    if ((missA || missB) && ErrCount == 6'd0)
                        FirstErrReg <= missA ? idx : idxB;
                    if (idx < 5'd30) begin
                        idx   <= idx + 5'd2;
                        state <= RD_SET;
                    end else if (passIdx != LAST_PASS) begin
                        passIdx <= passIdx + 2'd1;
                        idx     <= 5'd0;
                        RegWr   <= 1'b1;
                        RW      <= 5'd0;
                        BusW    <= wrVal(passIdx + 2'd1, 5'd0);
                        state   <= WRITE;
                    end else begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/regfile_bist.md
Name: regfile_bist

Overview:
- Built-in self-test initiator that drives the write and read side of the 32x32 RegisterFile (BusW/RW/RegWr write port, RA/RB read addresses, BusA/BusB read data).
- On Start it writes a known pattern to all 32 registers and reads every register back through both read ports.
- It confirms that $0 always reads zero and that registers 1..31 hold their written values, then reports pass/fail, an error count and the first failing register.
- It sits between the control logic and the RegisterFile and owns the register-file ports while busy.

Parameters:
SEED, 32'hA5C30F00, base data pattern.
PASSES, 2, number of write/read passes (1..4). Even-numbered passes (0, 2) use the true pattern; odd-numbered passes (1, 3) use the inverted pattern.

Ports:
Clk  in  1  clock, rising-edge.
Rst_n  in  1  synchronous active-low reset.
Start  in  1  begin test; sampled only in IDLE or DONE.
BusA  in  32  RegisterFile read data, port A (combinational read).
BusB  in  32  RegisterFile read data, port B (combinational read).
RA  out  5  read address A.
RB  out  5  read address B.
RW  out  5  write address.
BusW  out  32  write data.
RegWr  out  1  write enable.
Busy  out  1  test in progress.
Done  out  1  test complete; holds until the next Start or reset.
Pass  out  1  valid when Done=1; 1 iff ErrCount==0.
ErrCount  out  6  mismatch count, saturates at 63.
FirstErrReg  out  5  address of the first mismatching register; 0 if none.

Behaviour:
- Reset: one Clk edge with Rst_n=0 sets state=IDLE.
  - RA, RB, RW, BusW, RegWr, Busy, Done, Pass, ErrCount and FirstErrReg all go to 0.
  - This applies from any state, including mid-write; RegWr drops at that same edge.
- Expected value, pass p, register i:
  - E(p,i) = SEED ^ {27'b0,i} for even p; the bitwise inverse of that for odd p.
  - E(p,0) = 0 for every p.
  - Data written to $0 is always 32'hFFFFFFFF, to prove it is discarded.
- States: IDLE, WRITE, RD_SET, RD_CHK, DONE.
- IDLE / DONE:
  - Start=1 at an edge clears ErrCount, FirstErrReg, Done and Pass, sets Busy=1, p=0, idx=0, and enters WRITE.
- WRITE (one cycle per register):
  - RegWr=1, RW=idx, BusW = write data for (p, idx).
  - All three are registered and held stable for one full Clk period, so the RegisterFile commits within that period.
  - idx increments each cycle. After idx=31: RegWr=0, idx=0, go to RD_SET.
- RD_SET: RA=idx, RB=idx+1, RegWr=0. Go to RD_CHK.
- RD_CHK:
  - At the edge, compare BusA against E(p,idx) and BusB against E(p,idx+1).
  - Each mismatch adds 1 to ErrCount, saturating at 63. On the same edge, A and B mismatches add 2 (capped at 63).
  - The first mismatch since Start loads FirstErrReg. If both ports mismatch on that edge, the A address wins.
  - If idx<30: idx+=2, go to RD_SET.
  - Otherwise, if p<PASSES-1: p+=1, idx=0, go to WRITE.
  - Otherwise go to DONE.
- DONE: Busy=0, Done=1, Pass=(ErrCount==0).
- Latency: 64 cycles per pass. With PASSES=2, Done rises at the 129th rising edge after the edge that sampled Start.
- Start while Busy is ignored.
- RW, BusW and RegWr are 0 in IDLE and DONE.

Test Plan:
- Fault-free RegisterFile, PASSES=2, pulse Start -> Done=1 at edge 129 with Pass=1, ErrCount=0, FirstErrReg=0; write to $0 issued with BusW=32'hFFFFFFFF.
- Reg 5 bit 7 stuck-at-0 -> pass 0 clean (E=A5C30F05), pass 1 mismatch -> ErrCount=1, FirstErrReg=5, Pass=0.
- $0 writable (returns 32'hFFFFFFFF) -> one mismatch per pass -> ErrCount=2, FirstErrReg=0.
- RegisterFile ignores RegWr (all registers read 0) -> 31 mismatches per pass -> ErrCount=62. Same fault with PASSES=4 -> ErrCount saturates at 63.
- Rst_n=0 for one edge at cycle 40 of a run -> RegWr=0, Busy=0, Done=0, ErrCount=0 after that edge; a new Start gives a full clean run (Done at edge 129).
- Start held high through the run -> no restart while Busy; on reaching DONE with Start still 1, a new run starts at the next edge with counters cleared.
